// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: steps a PC through a small instruction memory
// and hands each word to the execution core over a valid/ready handshake.
module instr_fetch_seq #(
  parameter int         IMEM_DEPTH = 16,
  parameter int         ADDR_W     = 4,
  parameter logic [4:0] HALT_OP    = 5'b11111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] word;
  logic [4:0]  op;
  logic        is_halt, is_illegal, idle_like, go, accept;

  assign word       = imem[pc];
  assign op         = word[31:27];
  assign is_halt    = (op == HALT_OP);
  assign is_illegal = (op >= 5'd5) && (op <= 5'd30);
  assign idle_like  = (state == IDLE) || (state == HALTED);
  // a load in the same cycle as start wins; start is dropped
  assign go         = idle_like && start && !load_en;
  assign accept     = (state == ISSUE) && ir_ready;

  always_ff @(posedge clk) begin
    if (rst_n && load_en && idle_like)
      imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALTED: if (go) state_nxt = FETCH;
      FETCH: begin
        if (is_halt)         state_nxt = HALTED;
        else if (is_illegal) state_nxt = FETCH;
        else                 state_nxt = ISSUE;
      end
      ISSUE: if (accept) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    ir_valid = 1'b0;
    case (state)
      FETCH: busy = 1'b1;
      ISSUE: begin
        busy     = 1'b1;
        ir_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // PC, instruction buffer and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= '0;
      ir_out  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (go) begin
        pc      <= '0;
        halted  <= 1'b0;
        illegal <= 1'b0;
      end
      if (state == FETCH) begin
        ir_out <= word;
        if (is_halt) begin
          halted <= 1'b1;
        end else if (is_illegal) begin
          illegal <= 1'b1;
          pc      <= pc + ADDR_W'(1);
        end
      end
      if (accept)
        pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed timing scenarios plus randomized programs
// checked against a program-walk reference model.
module tb_instr_fetch_seq;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, load_en = 1'b0, ir_ready = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = '0;
  logic [31:0]   ir_out;
  logic          ir_valid, busy, halted, illegal;
  logic [AW-1:0] pc;

  logic [31:0] ref_mem [DEPTH];
  int n_chk = 0;
  int n_pass = 0;

  instr_fetch_seq #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .HALT_OP(5'b11111)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .ir_out(ir_out),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; load_en = 1'b0; ir_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_all();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = AW'(i); load_data = ref_mem[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Three-word program: ADI, MOVI, halt; exact cycle timing with ir_ready high
  task automatic scen1(input bit poke, input bit rst_mid);
    start = 1'b1; ir_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("s1_fetch_busy", busy, 1); chk("s1_fetch_valid", ir_valid, 0); chk("s1_fetch_pc", pc, 0);
    @(negedge clk);
    chk("s1_w0_valid", ir_valid, 1); chk("s1_w0", ir_out, 32'h10050004); chk("s1_w0_pc", pc, 0);
    if (poke) begin
      load_en = 1'b1; load_addr = AW'(1); load_data = 32'hF8000000; start = 1'b1;
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("rst_valid", ir_valid, 0); chk("rst_pc", pc, 0);
      chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    end else begin
      @(negedge clk); load_en = 1'b0; start = 1'b0;
      chk("s1_gap_valid", ir_valid, 0); chk("s1_gap_busy", busy, 1);
      @(negedge clk);
      chk("s1_w1_valid", ir_valid, 1); chk("s1_w1", ir_out, 32'h09010037); chk("s1_w1_pc", pc, 1);
      @(negedge clk);
      chk("s1_halt_fetch_valid", ir_valid, 0);
      @(negedge clk);
      chk("s1_halted", halted, 1); chk("s1_halt_pc", pc, 2);
      chk("s1_halt_busy", busy, 0); chk("s1_halt_valid", ir_valid, 0);
    end
  endtask

  task automatic scen_ill();
    start = 1'b1; ir_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("ill_clear", illegal, 0); chk("ill_busy", busy, 1);
    @(negedge clk);
    chk("ill_set", illegal, 1); chk("ill_no_issue", ir_valid, 0); chk("ill_skip_pc", pc, 1);
    @(negedge clk);
    chk("ill_w1_valid", ir_valid, 1); chk("ill_w1", ir_out, 32'h09010037); chk("ill_w1_pc", pc, 1);
    @(negedge clk);
    chk("ill_gap_valid", ir_valid, 0);
    @(negedge clk);
    chk("ill_halted", halted, 1); chk("ill_halt_pc", pc, 2); chk("ill_sticky", illegal, 1);
  endtask

  // Walks ref_mem from address 0 the way the sequencer should, then runs the DUT
  task automatic run_prog(input int max_issue, input bit rnd, input int stall);
    logic [31:0] exp_w[$];
    int          exp_pc[$];
    int          p = 0, halt_pc = -1, steps = 0, cyc = 0, stall_left = stall;
    bit          ill = 1'b0;
    logic [4:0]  op;
    while (exp_w.size() < max_issue && steps < DEPTH * (max_issue + 1)) begin
      op = ref_mem[p][31:27];
      steps++;
      if (op == 5'd31) begin
        halt_pc = p;
        break;
      end
      if (op >= 5'd5 && op <= 5'd30) ill = 1'b1;
      else begin
        exp_w.push_back(ref_mem[p]);
        exp_pc.push_back(p);
      end
      p = (p + 1) % DEPTH;
    end
    start = 1'b1; ir_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    while (exp_w.size() > 0 && cyc < 500) begin
      @(negedge clk); cyc++;
      ir_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ir_valid) begin
        if (stall_left > 0) begin
          ir_ready = 1'b0;
          stall_left--;
        end
        chk("issue_word", ir_out, exp_w[0]);
        chk("issue_pc", pc, exp_pc[0]);
        chk("issue_busy", busy, 1);
        if (ir_ready) begin
          void'(exp_w.pop_front());
          void'(exp_pc.pop_front());
        end
      end
    end
    chk("all_issued", exp_w.size(), 0);
    if (halt_pc >= 0) begin
      for (int i = 0; i < 8 && !halted; i++) begin
        @(negedge clk);
        if (ir_valid) chk("extra_issue", ir_valid, 0);
      end
      chk("run_halted", halted, 1); chk("run_halt_pc", pc, halt_pc);
      chk("run_halt_busy", busy, 0); chk("run_halt_valid", ir_valid, 0);
      chk("run_illegal", illegal, ill);
    end else begin
      chk("run_illegal", illegal, ill);
    end
  endtask

  initial begin
    do_reset();
    chk("reset_ir_out", ir_out, 0); chk("reset_valid", ir_valid, 0); chk("reset_pc", pc, 0);
    chk("reset_busy", busy, 0); chk("reset_halted", halted, 0); chk("reset_illegal", illegal, 0);

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_mem[0] = 32'h10050004; ref_mem[1] = 32'h09010037; ref_mem[2] = 32'hF8000000;
    load_all();
    scen1(1'b0, 1'b0);
    scen1(1'b1, 1'b0);
    scen1(1'b0, 1'b1);
    scen1(1'b0, 1'b0);
    run_prog(8, 1'b0, 5);

    ref_mem[0] = 32'h28000000;
    load_all();
    scen_ill();
    scen_ill();

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h08000000 | i;
    load_all();
    run_prog(18, 1'b0, 0);
    chk("wrap_busy", busy, 1);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        int   sel;
        logic [4:0] o;
        sel = $urandom_range(0, 9);
        if (i == 0 || sel < 6) o = 5'($urandom_range(0, 4));
        else if (sel < 8)      o = 5'($urandom_range(5, 30));
        else if (sel == 8)     o = 5'd31;
        else                   o = 5'($urandom_range(0, 4));
        ref_mem[i] = {o, 27'($urandom)};
      end
      load_all();
      run_prog(20, 1'b1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
Instruction fetch/issue sequencer that sits directly upstream of the AA execution core. It holds a small instruction memory and steps a program counter through it. Each 32-bit word is presented as the core's IR over a valid/ready handshake. Words use the core's IR format: oper_type IR[31:27], rdst IR[26:22], rsrc1 IR[21:17], imm_mode IR[16], rsrc2 IR[15:11], isrc IR[15:0].

Parameters:
IMEM_DEPTH, 16, number of 32-bit instruction words; power of two.
ADDR_W, 4, PC width; equals log2(IMEM_DEPTH).
HALT_OP, 5'b11111, oper_type value that stops the sequencer.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  begin execution from PC 0; sampled in IDLE/HALTED only.
load_en  input  1  write load_data into imem[load_addr]; honoured in IDLE/HALTED only.
load_addr  input  ADDR_W  program-load address.
load_data  input  32  program-load word.
ir_out  output  32  instruction to execution core.
ir_valid  output  1  ir_out is valid.
ir_ready  input  1  core accepts ir_out this cycle.
pc  output  ADDR_W  address of the instruction in flight.
busy  output  1  high in FETCH and ISSUE.
halted  output  1  HALT_OP reached.
illegal  output  1  sticky: an oper_type in 5'b00101..5'b11110 was fetched.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n: when rst_n=0 at a rising edge, state=IDLE, pc=0, ir_out=0, ir_valid=0, busy=0, halted=0, illegal=0. imem contents are not reset.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - load_en=1 writes imem; start is ignored in the same cycle (load has priority).
  - start=1 with load_en=0: pc<=0, next state FETCH.
- FETCH (1 cycle): synchronous read registers imem[pc] into ir_buf. Then:
  - oper_type==HALT_OP -> HALTED, halted<=1, nothing issued.
  - oper_type illegal (5..30) -> illegal<=1, pc<=pc+1, stay in FETCH, nothing issued.
  - otherwise -> ISSUE.
- ISSUE:
  - ir_out=ir_buf, ir_valid=1.
  - ir_out and pc stay stable while ir_ready=0.
  - On ir_valid&ir_ready: ir_valid<=0, pc<=pc+1, next state FETCH.
- HALTED: halted=1, busy=0, pc holds the halt word's address. load_en is accepted. start (load_en=0) clears halted, clears illegal, sets pc<=0, next state FETCH.
- PC arithmetic is modulo IMEM_DEPTH: pc=IMEM_DEPTH-1 increments to 0 with no flag. A program without HALT_OP loops forever.
- Latency and throughput:
  - start sampled at edge N -> FETCH in cycle N+1 -> ir_valid=1 in cycle N+2.
  - With ir_ready held high, one instruction is issued every 2 cycles.
- busy=1 exactly in FETCH/ISSUE.
- load_en and start in FETCH/ISSUE are ignored; memory is unchanged.
- ir_ready while ir_valid=0 has no effect.
- Reset mid-ISSUE drops the pending instruction: ir_valid=0 on the next cycle, with no handshake completed.

Test Plan:
- Program load and run: load imem[0]=0x10050004 (ADI rdst0 rsrc1 2 imm 4), imem[1]=0x09010037 (MOVI rdst4 imm 55), imem[2]=0xF8000000 (halt); pulse start, ir_ready=1 -> ir_out 0x10050004 with pc=0 at start+2, 0x09010037 with pc=1 at start+4, then halted=1 with pc=2 and busy=0; ir_valid never high for the halt word.
- Backpressure: same program with ir_ready=0 for 5 cycles after the first ir_valid -> ir_out=0x10050004, ir_valid=1 and pc=0 stable all 5 cycles; the first word is accepted once ir_ready rises.
- Illegal skip: imem[0]=0x28000000 (oper 5), imem[1]=0x09010037, imem[2]=halt -> illegal=1 from cycle start+2; the only issued word is 0x09010037 (pc=1); then halted. A subsequent start clears illegal.
- PC wrap: all 16 words = 0x08000000 (MOV), no halt, ir_ready=1 -> after 16 issues pc returns 0 and the next issue is imem[0]; busy stays 1.
- Ignored controls: during ISSUE drive load_en=1 (addr 1, data 0xF8000000) and start=1 -> imem[1] unchanged, and the sequence proceeds exactly as in scenario 1.
- Reset mid-operation: rst_n=0 for 1 cycle while ir_valid=1 -> next cycle ir_valid=0, pc=0, state IDLE, halted=0; imem contents intact, and a new start reruns the program identically.
